fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - IF stage of the 5-stage MIPS pipeline: owns the PC, drives the word address into
//   Instruction_memory, and captures its combinational read into the IF/ID pipeline register.
// - Handles hazard stall, branch/jump redirect (flush) and a halt instruction.
// - Feeds the decode stage.
// PARAMETERS
// - PC_W         32          PC width in bits; PC is a word index, +1 per instruction
// - RESET_PC     0           PC value after reset
// - HALT_OPCODE  6'b111111   instr[31:26] value that halts fetch
// PORTS
// - clk            in   1     rising-edge clock
// - rst            in   1     synchronous, active-high reset
// - stall          in   1     hazard unit: hold PC and IF/ID
// - redirect_valid in   1     EX: branch taken or jump; flush and load redirect_pc
// - redirect_pc    in   PC_W  target word address
// - instr_addr     out  32    to memory address; PC zero-extended to 32 bits
// - instr_rdata    in   32    from memory instruction, same cycle
// - ifid_instr     out  32    registered instruction
// - ifid_pc        out  PC_W  PC of ifid_instr
// - ifid_pc_plus1  out  PC_W  ifid_pc+1, mod 2^PC_W
// - ifid_valid     out  1     1 = real instruction, 0 = bubble
// - halted         out  1     fetch frozen by HALT_OPCODE
// BEHAVIOUR
// - Reset values: pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_pc_plus1=0, ifid_valid=0,
//   halted=0, state=RUN.
// - Reset applied mid-operation discards all in-flight state the same way.
// - States: RUN, HALTED. instr_addr = pc combinationally, in both states.
// - Per-edge priority: rst > redirect_valid > stall > halt detect > normal.
// - Redirect (any state):
//   pc<=redirect_pc; ifid_instr<=0, ifid_valid<=0; ifid_pc/pc_plus1 hold; state<=RUN; halted<=0.
//   The instruction fetched that cycle is dropped.
// - Stall (RUN, no redirect): pc and all ifid_* hold.
// - Normal (RUN): ifid_instr<=instr_rdata, ifid_pc<=pc, ifid_pc_plus1<=pc+1, ifid_valid<=1, pc<=pc+1.
//   One-cycle latency from address to IF/ID.
// - Halt detect (RUN, no stall/redirect, instr_rdata[31:26]==HALT_OPCODE):
//   halt word is captured as a normal fetch (valid=1); pc holds; state<=HALTED; halted<=1.
// - HALTED without redirect:
//   pc holds; IF/ID holds while stall=1, otherwise loads a bubble (instr=0, valid=0).
// - PC arithmetic: unsigned, mod 2^PC_W; pc=2^PC_W-1 wraps to 0 with no flag.
// - redirect_pc is used verbatim. No alignment check: addresses are word indices.
// FETCH_PERF_CNT_EN
// - Defined: adds ports fetch_cnt (out, 32) and flush_cnt (out, 32), both reset to 0.
//   - fetch_cnt +1 on every normal or halt-detect capture.
//   - flush_cnt +1 on every redirect_valid edge.
//   - Both saturate at 32'hFFFF_FFFF.
// - Undefined: ports and counters absent; all other behaviour identical.
// CONFIGURATION
// - Default build: PC_W=32, RESET_PC=0, FETCH_PERF_CNT_EN undefined.
// - Regression also builds PC_W=3 with FETCH_PERF_CNT_EN defined.
// TESTING
// - Memory model = 8-word program (add, lw, beq, slt, sll, addi, sw, add) at words 0-7; word 7
//   is replaced by the halt word (opcode 111111) in the halt test.
// - Reset release, no stall:
//   edge1 -> ifid_instr=mem[0], ifid_pc=0, ifid_pc_plus1=1, valid=1, instr_addr=1;
//   edge2 -> ifid_instr=mem[1].
// - stall=1 for 3 edges at pc=2:
//   pc=2 and ifid_instr=mem[1] unchanged; stall drop -> next edge ifid_instr=mem[2].
// - redirect_valid=1, redirect_pc=5 at pc=3:
//   next edge pc=5, ifid_valid=0, ifid_instr=0; following edge ifid_instr=mem[5], ifid_pc=5.
// - redirect_valid=1 and stall=1 same edge: redirect wins, pc=redirect_pc, bubble.
// - Halt at word 7:
//   ifid_instr=halt word, halted=1, pc stays 7, next edge ifid_valid=0;
//   redirect_pc=0 -> halted=0 and fetch resumes at 0.
// - PC_W=3, RESET_PC=6: pc 6,7,0,1.
//   rst=1 at pc=1 -> next edge pc=6, ifid_valid=0, halted=0.
//   With FETCH_PERF_CNT_EN: fetch_cnt counts captures, flush_cnt=1 after one redirect.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional perf counters (fetch_cnt, flush_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     instr_addr,
  input  logic [31:0]     instr_rdata,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic [PC_W-1:0] ifid_pc_plus1,
  output logic            ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            halted
);

  // state   | meaning
  // S_RUN    | fetching sequentially, one instruction per unstalled edge
  // S_HALTED | halt word captured; PC frozen until a redirect
  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic            halt_word;
  logic            do_capture;
  logic            do_bubble;

  assign pc_inc     = pc + PC_W'(1);
  assign halt_word  = (instr_rdata[31:26] == HALT_OPCODE);
  assign instr_addr = 32'(pc);

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = S_RUN;
    else if (!stall && state == S_RUN && halt_word)
      state_nxt = S_HALTED;
  end

  always_comb begin
    pc_nxt     = pc;
    do_capture = 1'b0;
    do_bubble  = 1'b0;
    halted     = (state == S_HALTED);
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      do_bubble = 1'b1;
    end else if (!stall) begin
      if (state == S_RUN) begin
        do_capture = 1'b1;
        // The halt word itself is delivered; the PC stays on it.
        if (!halt_word) pc_nxt = pc_inc;
      end else begin
        do_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (do_capture) begin
        ifid_instr    <= instr_rdata;
        ifid_pc       <= pc;
        ifid_pc_plus1 <= pc_inc;
        ifid_valid    <= 1'b1;
      end else if (do_bubble) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_capture && fetch_cnt != 32'hFFFF_FFFF)     fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 32-bit-PC instance and a 3-bit-PC (RESET_PC=6) instance,
// directed scenario steps followed by random stimulus against a rule-level reference model.
module tb_fetch_stage;

  logic clk;

  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, instr_addr, instr_rdata, ifid_instr, ifid_pc, ifid_pc_plus1;
  logic        ifid_valid, halted;

  logic        rst_s, stall_s, rv_s;
  logic [2:0]  rpc_s, ifid_pc_s, ifid_pc_plus1_s;
  logic [31:0] instr_addr_s, instr_rdata_s, ifid_instr_s;
  logic        ifid_valid_s, halted_s;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt, fetch_cnt_s, flush_cnt_s;
`endif

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic [31:0] prog [8];
  logic [31:0] mem  [8];

  int total  = 0;
  int passed = 0;

  longint      m_pc   [2];
  longint      m_ifpc [2];
  longint      m_ifpc1[2];
  logic [31:0] m_instr[2];
  bit          m_valid[2];
  bit          m_halted[2];
  longint      m_fetch[2];
  longint      m_flush[2];

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
    .halted(halted)
  );

  fetch_stage #(.PC_W(3), .RESET_PC(3'd6)) u_small (
    .clk(clk), .rst(rst_s), .stall(stall_s), .redirect_valid(rv_s),
    .redirect_pc(rpc_s), .instr_addr(instr_addr_s), .instr_rdata(instr_rdata_s),
    .ifid_instr(ifid_instr_s), .ifid_pc(ifid_pc_s), .ifid_pc_plus1(ifid_pc_plus1_s),
    .ifid_valid(ifid_valid_s),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt_s), .flush_cnt(flush_cnt_s),
`endif
    .halted(halted_s)
  );

  assign instr_rdata   = (instr_addr < 32'd8) ? mem[instr_addr[2:0]] : 32'h0;
  assign instr_rdata_s = prog[instr_addr_s[2:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_b(input longint a);
    if (a >= 0 && a < 8) return mem[int'(a)];
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Rule-level model of one clock edge, PC kept as an integer modulo modv.
  task automatic m_upd(input int k, input bit r, input bit st, input bit rv,
                       input longint rpc, input logic [31:0] rdata,
                       input longint modv, input longint rstpc);
    if (r) begin
      m_pc[k] = rstpc; m_instr[k] = 0; m_ifpc[k] = 0; m_ifpc1[k] = 0;
      m_valid[k] = 0; m_halted[k] = 0; m_fetch[k] = 0; m_flush[k] = 0;
    end else if (rv) begin
      m_pc[k] = rpc; m_instr[k] = 0; m_valid[k] = 0; m_halted[k] = 0;
      m_flush[k]++;
    end else if (!st) begin
      if (!m_halted[k]) begin
        m_instr[k] = rdata; m_ifpc[k] = m_pc[k]; m_ifpc1[k] = (m_pc[k] + 1) % modv;
        m_valid[k] = 1; m_fetch[k]++;
        if (rdata[31:26] == 6'b111111) m_halted[k] = 1;
        else m_pc[k] = (m_pc[k] + 1) % modv;
      end else begin
        m_instr[k] = 0; m_valid[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("addr",     64'(instr_addr),    64'(m_pc[0]));
    chk("instr",    64'(ifid_instr),    64'(m_instr[0]));
    chk("pc",       64'(ifid_pc),       64'(m_ifpc[0]));
    chk("pc1",      64'(ifid_pc_plus1), 64'(m_ifpc1[0]));
    chk("valid",    64'(ifid_valid),    64'(m_valid[0]));
    chk("halted",   64'(halted),        64'(m_halted[0]));
    chk("s_addr",   64'(instr_addr_s),  64'(m_pc[1]));
    chk("s_instr",  64'(ifid_instr_s),  64'(m_instr[1]));
    chk("s_pc",     64'(ifid_pc_s),     64'(m_ifpc[1]));
    chk("s_pc1",    64'(ifid_pc_plus1_s), 64'(m_ifpc1[1]));
    chk("s_valid",  64'(ifid_valid_s),  64'(m_valid[1]));
    chk("s_halted", 64'(halted_s),      64'(m_halted[1]));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt",   64'(fetch_cnt),   64'(m_fetch[0]));
    chk("flush_cnt",   64'(flush_cnt),   64'(m_flush[0]));
    chk("s_fetch_cnt", 64'(fetch_cnt_s), 64'(m_fetch[1]));
    chk("s_flush_cnt", 64'(flush_cnt_s), 64'(m_flush[1]));
`endif
  endtask

  task automatic step();
    m_upd(0, rst, stall, redirect_valid, longint'(redirect_pc), mem_b(m_pc[0]), 64'h1_0000_0000, 0);
    m_upd(1, rst_s, stall_s, rv_s, longint'(rpc_s), prog[int'(m_pc[1] % 8)], 8, 6);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    prog[0] = 32'h0043_0820;  // add
    prog[1] = 32'h8C22_0004;  // lw
    prog[2] = 32'h1022_0002;  // beq
    prog[3] = 32'h0062_082A;  // slt
    prog[4] = 32'h0002_1080;  // sll
    prog[5] = 32'h2021_0001;  // addi
    prog[6] = 32'hAC22_0008;  // sw
    prog[7] = 32'h0022_1820;  // add
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_ifpc[i] = 0; m_ifpc1[i] = 0; m_instr[i] = 0;
      m_valid[i] = 0; m_halted[i] = 0; m_fetch[i] = 0; m_flush[i] = 0;
    end

    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    rst_s = 1; stall_s = 0; rv_s = 0; rpc_s = 0;
    #2;
    step(); step();
    chk("rst_valid", 64'(ifid_valid), 64'd0);
    chk("rst_instr", 64'(ifid_instr), 64'd0);
    chk("s_rst_addr", 64'(instr_addr_s), 64'd6);

    rst = 0; rst_s = 0;
    step();
    chk("e1_instr", 64'(ifid_instr), 64'(prog[0]));
    chk("e1_pc1", 64'(ifid_pc_plus1), 64'd1);
    chk("e1_addr", 64'(instr_addr), 64'd1);
    chk("s_wrap7", 64'(instr_addr_s), 64'd7);
    step();
    chk("e2_instr", 64'(ifid_instr), 64'(prog[1]));
    chk("s_wrap0", 64'(instr_addr_s), 64'd0);

    stall = 1;
    step();
    chk("s_wrap1", 64'(instr_addr_s), 64'd1);
    rst_s = 1;
    step();
    chk("s_rst_mid", 64'(instr_addr_s), 64'd6);
    chk("s_rst_valid", 64'(ifid_valid_s), 64'd0);
    rst_s = 0;
    step();
    chk("stall_addr", 64'(instr_addr), 64'd2);
    chk("stall_instr", 64'(ifid_instr), 64'(prog[1]));
    stall = 0;
    step();
    chk("unstall_instr", 64'(ifid_instr), 64'(prog[2]));

    redirect_valid = 1; redirect_pc = 5; rv_s = 1; rpc_s = 3;
    step();
    chk("redir_addr", 64'(instr_addr), 64'd5);
    chk("redir_valid", 64'(ifid_valid), 64'd0);
    chk("s_redir_addr", 64'(instr_addr_s), 64'd3);
`ifdef FETCH_PERF_CNT_EN
    chk("s_flush_one", 64'(flush_cnt_s), 64'd1);
`endif
    redirect_valid = 0; rv_s = 0;
    step();
    chk("redir_instr", 64'(ifid_instr), 64'(prog[5]));
    chk("redir_pc", 64'(ifid_pc), 64'd5);

    redirect_valid = 1; stall = 1; redirect_pc = 2;
    step();
    chk("rs_addr", 64'(instr_addr), 64'd2);
    chk("rs_valid", 64'(ifid_valid), 64'd0);

    mem[7] = HALT_W;
    stall = 0; redirect_pc = 6;
    step();
    redirect_valid = 0;
    step();
    step();
    chk("halt_instr", 64'(ifid_instr), 64'(HALT_W));
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_addr", 64'(instr_addr), 64'd7);
    step();
    chk("halt_bubble", 64'(ifid_valid), 64'd0);
    chk("halt_hold", 64'(instr_addr), 64'd7);
    redirect_valid = 1; redirect_pc = 0;
    step();
    chk("unhalt_flag", 64'(halted), 64'd0);
    redirect_valid = 0;
    step();
    chk("resume_instr", 64'(ifid_instr), 64'(prog[0]));

    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 59) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = 32'($urandom_range(0, 9));
      rst_s          = ($urandom_range(0, 59) == 0);
      stall_s        = ($urandom_range(0, 3) == 0);
      rv_s           = ($urandom_range(0, 7) == 0);
      rpc_s          = 3'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
